// File: rtl/key_scan.sv
// key_scan: 4x4 matrix keypad scanner/encoder with debounce.
// Walks a low level across the columns, samples the active-low rows through a
// 2-flop synchronizer and accepts a single pressed key after DEBOUNCE_CNT
// matching scan ticks. Release is debounced the same way.
// Optional feature: define KEY_REPEAT_EN for auto-repeat pulses while held.
module key_scan #(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CNT = 4,
  parameter int REPEAT_DELAY = 64,
  parameter int REPEAT_RATE  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pulse
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CNT + 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t            state, state_nx;
  logic [3:0]        row_s1, row_s2;
  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  logic [1:0]        col_idx, col_idx_nx;
  logic [1:0]        row_idx, row_idx_nx;
  logic [DB_W-1:0]   db_cnt, db_cnt_nx, db_inc;
  logic [3:0]        key_code_nx;
  logic              key_valid_nx, key_pulse_nx;
  logic              single;
  logic [1:0]        low_idx;
  logic [3:0]        cap_row;

`ifdef KEY_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0]  rpt_cnt, rpt_cnt_nx, rpt_inc;
  logic              rpt_on, rpt_on_nx;
`else
  // Repeat timing has no effect when auto-repeat is compiled out.
  localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_RATE;
`endif

  assign tick    = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign col     = ~(4'b0001 << col_idx);
  assign cap_row = ~(4'b0001 << row_idx);

  // Two-flop synchronizer for the asynchronous row inputs (idle = all high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
    end
  end

  // Scan tick divider: one tick every SCAN_DIV clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Decode "exactly one row low" and which row it is.
  always_comb begin
    single  = 1'b1;
    low_idx = 2'd0;
    case (row_s2)
      4'b1110: low_idx = 2'd0;
      4'b1101: low_idx = 2'd1;
      4'b1011: low_idx = 2'd2;
      4'b0111: low_idx = 2'd3;
      default: single  = 1'b0;
    endcase
  end

  // Next-state and output logic; everything advances only on a scan tick.
  always_comb begin
    state_nx     = state;
    col_idx_nx   = col_idx;
    row_idx_nx   = row_idx;
    db_cnt_nx    = db_cnt;
    db_inc       = db_cnt + 1'b1;
    key_code_nx  = key_code;
    key_valid_nx = key_valid;
    key_pulse_nx = 1'b0;
`ifdef KEY_REPEAT_EN
    rpt_cnt_nx   = rpt_cnt;
    rpt_on_nx    = rpt_on;
    rpt_inc      = rpt_cnt + 1'b1;
`endif
    if (tick) begin
      case (state)
        SCAN: begin
          if (single) begin
            row_idx_nx = low_idx;
            db_cnt_nx  = '0;
            state_nx   = DEBOUNCE;
          end else begin
            col_idx_nx = col_idx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (row_s2 == cap_row) begin
            if (db_inc == DB_W'(DEBOUNCE_CNT)) begin
              state_nx     = HELD;
              key_code_nx  = {row_idx, col_idx};
              key_valid_nx = 1'b1;
              key_pulse_nx = 1'b1;
`ifdef KEY_REPEAT_EN
              rpt_cnt_nx   = '0;
              rpt_on_nx    = 1'b0;
`endif
            end else begin
              db_cnt_nx = db_inc;
            end
          end else begin
            state_nx = SCAN;
          end
        end
        HELD: begin
          if (row_s2 == 4'hF) begin
            state_nx  = RELEASE;
            db_cnt_nx = '0;
          end
`ifdef KEY_REPEAT_EN
          else if ((!rpt_on && rpt_inc == RPT_W'(REPEAT_DELAY)) ||
                   (rpt_on && rpt_inc == RPT_W'(REPEAT_RATE))) begin
            key_pulse_nx = 1'b1;
            rpt_cnt_nx   = '0;
            rpt_on_nx    = 1'b1;
          end else begin
            rpt_cnt_nx = rpt_inc;
          end
`endif
        end
        RELEASE: begin
          if (row_s2 == 4'hF) begin
            if (db_inc == DB_W'(DEBOUNCE_CNT)) begin
              key_valid_nx = 1'b0;
              col_idx_nx   = col_idx + 2'd1;
              state_nx     = SCAN;
            end else begin
              db_cnt_nx = db_inc;
            end
          end else begin
            state_nx  = HELD;
            db_cnt_nx = '0;
`ifdef KEY_REPEAT_EN
            rpt_cnt_nx = '0;
            rpt_on_nx  = 1'b0;
`endif
          end
        end
        default: state_nx = SCAN;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      db_cnt    <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_pulse <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt_cnt   <= '0;
      rpt_on    <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      col_idx   <= col_idx_nx;
      row_idx   <= row_idx_nx;
      db_cnt    <= db_cnt_nx;
      key_code  <= key_code_nx;
      key_valid <= key_valid_nx;
      key_pulse <= key_pulse_nx;
`ifdef KEY_REPEAT_EN
      rpt_cnt   <= rpt_cnt_nx;
      rpt_on    <= rpt_on_nx;
`endif
    end
  end

endmodule
